// File: rtl/onehot_phase_seq.sv
// Purpose: one-hot phase sequencer stepping N_PHASES phases for N_ROUNDS rotations per op.
// Latency: N_PHASES*N_ROUNDS enabled cycles after begin_op; done pulses the cycle after the last advance.
// Backpressure: enable=0 freezes phase and round; begin_op restarts at any time.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (highest priority)
//   begin_op   start/restart an operation (aborts a running op without done)
//   enable     advance one phase this cycle, ignored while idle
//   state      one-hot phase, bit i = Qi
//   round      completed rotations in the current op, 0..N_ROUNDS-1
//   busy       operation in progress (always 1 when FREE_RUN=1)
//   last_phase combinational: final phase of the final round while busy
//   done       one-cycle pulse when an op completes
//   err        one-cycle pulse when a non-one-hot state was detected and corrected

module onehot_phase_seq #(
   parameter int N_PHASES = 3,
   parameter int N_ROUNDS = 1,
   parameter int FREE_RUN = 0,
   localparam int RW = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                begin_op,
   input  logic                enable,
   output logic [N_PHASES-1:0] state,
   output logic [RW-1:0]       round,
   output logic                busy,
   output logic                last_phase,
   output logic                done,
   output logic                err
);

   localparam logic [N_PHASES-1:0] Q0    = {{(N_PHASES-1){1'b0}}, 1'b1};
   localparam logic [N_PHASES-1:0] QLAST = {1'b1, {(N_PHASES-1){1'b0}}};
   localparam logic [RW-1:0]       ROUND_LAST = RW'(N_ROUNDS - 1);
   // Idle value of busy: a free-running sequencer never leaves the busy state.
   localparam logic                BUSY_IDLE  = (FREE_RUN != 0);

   logic state_legal;
   logic at_qlast;
   logic final_round;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   assign state_legal = (state != '0) && ((state & (state - 1'b1)) == '0);
   assign at_qlast    = (state == QLAST);
   assign final_round = (round == ROUND_LAST);
   assign last_phase  = at_qlast && final_round && busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= Q0;
         round <= '0;
         busy  <= BUSY_IDLE;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (!state_legal) begin
            // Corrupted state: recover to Q0 and drop any op in flight,
            // including a begin_op arriving in the same cycle.
            state <= Q0;
            round <= '0;
            busy  <= BUSY_IDLE;
            err   <= 1'b1;
         end else if (begin_op) begin
            state <= Q0;
            round <= '0;
            busy  <= 1'b1;
         end else if (busy && enable) begin
            // Rotate left; QLAST wraps naturally back to Q0.
            state <= {state[N_PHASES-2:0], state[N_PHASES-1]};
            if (at_qlast) begin
               if (final_round) begin
                  round <= '0;
                  done  <= 1'b1;
                  busy  <= BUSY_IDLE;
               end else begin
                  round <= round + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_onehot_phase_seq.sv
// Purpose: directed bench for onehot_phase_seq across several parameter sets.
// Latency: each step drives inputs, waits one rising edge, then compares.
// Backpressure: enable gaps exercised directly; no flow control in the bench itself.

module tb_onehot_phase_seq;

   logic clk = 1'b0;
   logic reset;
   logic begin_op;
   logic enable;

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] state;
      logic [1:0] round;
      logic       busy;
      logic       last;
      logic       done;
      logic       err;
   } obs_t;

   // N=3 R=1
   logic [2:0] a_state; logic [0:0] a_round; logic a_busy, a_last, a_done, a_err;
   // N=4 R=3
   logic [3:0] b_state; logic [1:0] b_round; logic b_busy, b_last, b_done, b_err;
   // N=4 R=2
   logic [3:0] c_state; logic [0:0] c_round; logic c_busy, c_last, c_done, c_err;
   // N=3 R=1 free-running
   logic [2:0] f_state; logic [0:0] f_round; logic f_busy, f_last, f_done, f_err;

   onehot_phase_seq #(.N_PHASES(3), .N_ROUNDS(1), .FREE_RUN(0)) u3 (
      .clk(clk), .reset(reset), .begin_op(begin_op), .enable(enable),
      .state(a_state), .round(a_round), .busy(a_busy), .last_phase(a_last),
      .done(a_done), .err(a_err));

   onehot_phase_seq #(.N_PHASES(4), .N_ROUNDS(3), .FREE_RUN(0)) u43 (
      .clk(clk), .reset(reset), .begin_op(begin_op), .enable(enable),
      .state(b_state), .round(b_round), .busy(b_busy), .last_phase(b_last),
      .done(b_done), .err(b_err));

   onehot_phase_seq #(.N_PHASES(4), .N_ROUNDS(2), .FREE_RUN(0)) u42 (
      .clk(clk), .reset(reset), .begin_op(begin_op), .enable(enable),
      .state(c_state), .round(c_round), .busy(c_busy), .last_phase(c_last),
      .done(c_done), .err(c_err));

   onehot_phase_seq #(.N_PHASES(3), .N_ROUNDS(1), .FREE_RUN(1)) ufr (
      .clk(clk), .reset(reset), .begin_op(begin_op), .enable(enable),
      .state(f_state), .round(f_round), .busy(f_busy), .last_phase(f_last),
      .done(f_done), .err(f_err));

   int   sel;
   obs_t obs;

   always_comb begin
      obs = '0;
      case (sel)
         0:       obs = {1'b0, a_state, 1'b0, a_round, a_busy, a_last, a_done, a_err};
         1:       obs = {b_state, b_round, b_busy, b_last, b_done, b_err};
         2:       obs = {c_state, 1'b0, c_round, c_busy, c_last, c_done, c_err};
         default: obs = {1'b0, f_state, 1'b0, f_round, f_busy, f_last, f_done, f_err};
      endcase
   end

   obs_t  exp_q[$];
   string tag_q[$];
   int    nchk  = 0;
   int    npass = 0;

   function automatic obs_t mk(input logic [3:0] s, input logic [1:0] r,
                               input logic b, input logic l, input logic d, input logic e);
      obs_t o;
      o = {s, r, b, l, d, e};
      return o;
   endfunction

   task automatic check_out();
      obs_t  x;
      string t;
      x = exp_q.pop_front();
      t = tag_q.pop_front();
      nchk++;
      assert (obs === x) npass++;
      else $error("FAIL %s: observed %b expected %b", t, obs, x);
   endtask

   // Drive inputs, queue the expected post-edge outputs, then compare after the edge.
   task automatic step(input string tag, input logic bo, input logic en, input obs_t e);
      begin_op = bo;
      enable   = en;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      check_out();
   endtask

   // Enabled advances k=from..to on an N=4 instance with nr rounds (no completion).
   task automatic adv4(input string pfx, input int from, input int to, input int nr);
      for (int k = from; k <= to; k++) begin
         step($sformatf("%s_adv%0d", pfx, k), 1'b0, 1'b1,
              mk(4'(1 << (k % 4)), 2'(k / 4), 1'b1,
                 ((k % 4) == 3) && ((k / 4) == nr - 1), 1'b0, 1'b0));
      end
   endtask

   initial begin
      reset    = 1'b1;
      begin_op = 1'b0;
      enable   = 1'b0;
      sel      = 0;
      @(posedge clk);
      #1;

      // T1: N=3 R=1 single op
      step("t1_rst", 1'b0, 1'b0, mk(4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      reset = 1'b0;
      step("t1_begin", 1'b1, 1'b1, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      step("t1_q1",    1'b0, 1'b1, mk(4'b0010, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      step("t1_q2",    1'b0, 1'b1, mk(4'b0100, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
      step("t1_done",  1'b0, 1'b1, mk(4'b0001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      step("t1_idle",  1'b0, 1'b1, mk(4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      // T2: N=4 R=3, 12 advances
      sel = 1;
      step("t2_begin", 1'b1, 1'b1, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      adv4("t2", 1, 11, 3);
      step("t2_done",  1'b0, 1'b1, mk(4'b0001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      step("t2_idle",  1'b0, 1'b1, mk(4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      // T3: N=4 R=2 with enable gaps
      sel = 2;
      step("t3_begin", 1'b1, 1'b0, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      step("t3_e1",    1'b0, 1'b1, mk(4'b0010, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      step("t3_hold1", 1'b0, 1'b0, mk(4'b0010, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      step("t3_hold2", 1'b0, 1'b0, mk(4'b0010, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      adv4("t3", 2, 7, 2);
      step("t3_done",  1'b0, 1'b1, mk(4'b0001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));

      // T4: restart mid-op, and begin_op beating the final advance
      step("t4_begin", 1'b1, 1'b1, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      adv4("t4a", 1, 6, 2);
      step("t4_restart", 1'b1, 1'b1, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      adv4("t4b", 1, 7, 2);
      step("t4_begin_vs_final", 1'b1, 1'b1, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      adv4("t4c", 1, 5, 2);

      // T5: illegal-state recovery (busy at 0010 round 1, then idle)
      force u42.state = 4'b0110;
      #1;
      release u42.state;
      step("t5_0110",  1'b1, 1'b1, mk(4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
      step("t5_clr1",  1'b0, 1'b1, mk(4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      force u42.state = 4'b0000;
      #1;
      release u42.state;
      step("t5_0000",  1'b0, 1'b1, mk(4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
      step("t5_clr2",  1'b0, 1'b1, mk(4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      // T6: free-running N=3 R=1
      sel   = 3;
      reset = 1'b1;
      step("t6_rst",   1'b0, 1'b1, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      reset = 1'b0;
      step("t6_q1",    1'b0, 1'b1, mk(4'b0010, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      step("t6_q2",    1'b0, 1'b1, mk(4'b0100, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
      step("t6_wrap1", 1'b0, 1'b1, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
      step("t6_q1b",   1'b0, 1'b1, mk(4'b0010, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      step("t6_hold",  1'b0, 1'b0, mk(4'b0010, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      step("t6_q2b",   1'b0, 1'b1, mk(4'b0100, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
      step("t6_wrap2", 1'b0, 1'b1, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
      step("t6_q1c",   1'b0, 1'b1, mk(4'b0010, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      reset = 1'b1;
      step("t6_midrst", 1'b0, 1'b1, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      reset = 1'b0;
      step("t6_after", 1'b0, 1'b1, mk(4'b0010, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
